// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// audio_pkg : I2S frame constants, sample word layout and bit-slot helpers
// Revision  : 1.0
// ============================================================================
package audio_pkg;

  localparam int FRAME_BITS = 32;
  localparam int CH_BITS    = 16;
  localparam int LEFT_MSB   = 31;
  localparam int RIGHT_MSB  = 15;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  typedef logic [BIT_W-1:0] bitcnt_t;

  typedef struct packed {
    logic [CH_BITS-1:0] left;
    logic [CH_BITS-1:0] right;
  } sample_t;

  localparam bitcnt_t LAST_BIT = bitcnt_t'(FRAME_BITS - 1);

  // Word select leads the right-channel MSB slot by one bit and drops on the last slot.
  function automatic logic lrclk_for(input bitcnt_t b);
    return (b >= bitcnt_t'(LEFT_MSB - RIGHT_MSB - 1)) && (b != LAST_BIT);
  endfunction

  function automatic logic sdata_for(input logic [FRAME_BITS-1:0] w, input bitcnt_t b);
    return w[bitcnt_t'(LEFT_MSB) - b];
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_sample_fifo.sv
`default_nettype none
// ============================================================================
// audio_sample_fifo : single-clock sample FIFO, show-ahead read, no bypass
// Revision          : 1.0
// ============================================================================
module audio_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit separates full from empty when the indices match.
  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (level == (AW+1)'(DEPTH));
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// axi_audio_i2s_tx : buffered Philips I2S transmitter, BCLK/LRCLK from ACLK
// Revision         : 1.0
// ============================================================================
module axi_audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int BCLK_DIV   = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [31:0]                   s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          enable,
  input  logic                          underrun_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sdata
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic             ready_en;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [31:0]      fifo_dout;
  logic [DIV_W-1:0] div_cnt;
  bitcnt_t          bitcnt;
  bitcnt_t          bit_nxt;
  sample_t          shreg;
  sample_t          word_nxt;
  logic             fall;
  logic             frame_start;

  assign s_ready     = ready_en && !fifo_full;
  assign fall        = enable && (div_cnt == DIV_LAST) && i2s_bclk;
  assign frame_start = fall && (bitcnt == LAST_BIT);
  assign fifo_pop    = frame_start && !fifo_empty;
  assign bit_nxt     = bitcnt + bitcnt_t'(1);
  // An empty FIFO at frame start transmits a silent frame.
  assign word_nxt    = !frame_start ? shreg : (fifo_empty ? '0 : sample_t'(fifo_dout));

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (s_valid && s_ready),
    .pop   (fifo_pop),
    .din   (s_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ready_en  <= 1'b0;
      underrun  <= 1'b0;
      div_cnt   <= '0;
      bitcnt    <= LAST_BIT;
      shreg     <= '0;
      i2s_bclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (frame_start && fifo_empty) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end

      if (!enable) begin
        div_cnt   <= '0;
        bitcnt    <= LAST_BIT;
        shreg     <= '0;
        i2s_bclk  <= 1'b0;
        i2s_lrclk <= 1'b0;
        i2s_sdata <= 1'b0;
      end else begin
        if (div_cnt == DIV_LAST) begin
          div_cnt  <= '0;
          i2s_bclk <= !i2s_bclk;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
        // Data and word select move on the falling toggle so they are stable at the rise.
        if (fall) begin
          bitcnt    <= bit_nxt;
          shreg     <= word_nxt;
          i2s_sdata <= sdata_for(word_nxt, bit_nxt);
          i2s_lrclk <= lrclk_for(bit_nxt);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// tb_axi_audio_i2s_tx : directed scoreboard bench with an independent I2S receiver
// Revision            : 1.0
// ============================================================================
module tb_axi_audio_i2s_tx;

  localparam int FIFO_DEPTH = 16;
  localparam int BCLK_DIV   = 4;
  localparam int FRAME_CYC  = 64 * BCLK_DIV;
  localparam logic [31:0] LR_PATTERN = 32'h0001_FFFE;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        enable = 1'b0;
  logic        underrun_clr = 1'b0;
  logic        s_ready;
  logic [4:0]  fifo_level;
  logic        underrun;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int frames = 0;
  int cyc = 0;
  logic [31:0] sb[$];

  axi_audio_i2s_tx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BCLK_DIV   (BCLK_DIV)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .enable       (enable),
    .underrun_clr (underrun_clr),
    .fifo_level   (fifo_level),
    .underrun     (underrun),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Receiver: samples on BCLK rise; the first rise after enable is the slot before left MSB.
  logic        rx_prev = 1'b0;
  logic        rx_pre = 1'b1;
  int          rx_k = 0;
  logic [31:0] rx_word = '0;
  logic [31:0] rx_lr = '0;
  logic [31:0] rx_exp = '0;

  always @(negedge ACLK) begin
    if (ARESET || !enable) begin
      rx_pre = 1'b1;
      rx_k   = 0;
    end else if (i2s_bclk && !rx_prev) begin
      if (rx_pre) begin
        rx_pre = 1'b0;
      end else begin
        if (rx_k == 0) rx_exp = (sb.size() > 0) ? sb.pop_front() : 32'h0;
        rx_word = {rx_word[30:0], i2s_sdata};
        rx_lr   = {rx_lr[30:0], i2s_lrclk};
        rx_k++;
        if (rx_k == 32) begin
          check("frame_data", rx_word, rx_exp);
          check("frame_lrclk", rx_lr, LR_PATTERN);
          rx_k = 0;
          frames++;
        end
      end
    end
    rx_prev = i2s_bclk;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 2 * FRAME_CYC) begin
      tick(1);
      n++;
    end
    check("push_accept", 32'(s_ready), 32'd1);
    if (s_ready) sb.push_back(d);
    tick(1);
    s_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    int budget = (target - frames + 1) * FRAME_CYC;
    while (frames < target && n < budget) begin
      tick(1);
      n++;
    end
    check("frames_done", 32'(frames >= target), 32'd1);
  endtask

  task automatic wait_falls(input int cnt);
    int   seen = 0;
    int   n = 0;
    logic prev = i2s_bclk;
    while (seen < cnt && n < (cnt + 2) * 2 * BCLK_DIV) begin
      tick(1);
      n++;
      if (prev && !i2s_bclk) seen++;
      prev = i2s_bclk;
    end
    check("falls_seen", 32'(seen), 32'(cnt));
  endtask

  task automatic wait_lr_rise(output int t);
    int   n = 0;
    logic prev = i2s_lrclk;
    t = -1;
    while (n < 2 * FRAME_CYC) begin
      tick(1);
      n++;
      if (!prev && i2s_lrclk) begin
        t = cyc;
        break;
      end
      prev = i2s_lrclk;
    end
    check("lr_rise_seen", 32'(t >= 0), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check(tag, {29'd0, i2s_bclk, i2s_lrclk, i2s_sdata}, 32'd0);
  endtask

  initial begin
    int f0;
    int t1;
    int t2;

    // Reset state
    tick(3);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check_idle("rst_pins");
    ARESET = 1'b0;
    tick(1);
    check("rst_release_ready", 32'(s_ready), 32'd1);

    // Basic frame and first-edge timing
    push(32'h0101_FFFF);
    check("basic_level1", 32'(fifo_level), 32'd1);
    f0 = frames;
    enable = 1'b1;
    tick(BCLK_DIV - 1);
    check("pre_first_rise", 32'(i2s_bclk), 32'd0);
    tick(1);
    check("first_rise", 32'(i2s_bclk), 32'd1);
    tick(BCLK_DIV - 1);
    check("pre_first_pop", 32'(fifo_level), 32'd1);
    tick(1);
    check("first_pop_level", 32'(fifo_level), 32'd0);
    check("first_fall", 32'(i2s_bclk), 32'd0);
    wait_frames(f0 + 1);
    enable = 1'b0;
    tick(1);
    check("basic_underrun", 32'(underrun), 32'd0);
    check_idle("basic_idle");

    // Full FIFO, held 17th word, in-order drain
    for (int i = 0; i < FIFO_DEPTH; i++) push(32'hABCD_0001 + 32'(i));
    check("full_level", 32'(fifo_level), 32'd16);
    check("full_ready", 32'(s_ready), 32'd0);
    f0 = frames;
    enable  = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hABCD_0011;
    tick(2 * BCLK_DIV - 1);
    check("full_hold", 32'(s_ready), 32'd0);
    push(32'hABCD_0011);
    check("full_refill_level", 32'(fifo_level), 32'd16);
    wait_frames(f0 + 17);
    enable = 1'b0;
    tick(1);
    check("full_drained", 32'(fifo_level), 32'd0);

    // Underrun: set on empty frame start, set beats clear
    enable = 1'b1;
    tick(2 * BCLK_DIV - 1);
    check("ur_pre", 32'(underrun), 32'd0);
    tick(1);
    check("ur_set", 32'(underrun), 32'd1);
    tick(FRAME_CYC - 1);
    underrun_clr = 1'b1;
    tick(1);
    underrun_clr = 1'b0;
    check("ur_set_wins", 32'(underrun), 32'd1);
    enable = 1'b0;
    tick(1);
    underrun_clr = 1'b1;
    tick(1);
    underrun_clr = 1'b0;
    check("ur_clear", 32'(underrun), 32'd0);

    // Back-to-back frames and LRCLK period
    push(32'hDEAD_0011);
    push(32'hBEEF_0011);
    f0 = frames;
    enable = 1'b1;
    wait_lr_rise(t1);
    wait_lr_rise(t2);
    check("lr_period", 32'(t2 - t1), 32'(64 * BCLK_DIV));
    wait_frames(f0 + 2);
    enable = 1'b0;
    tick(1);

    // Reset mid-frame at bitcnt 10
    push(32'h1111_2222);
    push(32'h3333_4444);
    push(32'h5555_6666);
    enable = 1'b1;
    wait_falls(11);
    ARESET = 1'b1;
    tick(1);
    sb.delete();
    check("mrst_level", 32'(fifo_level), 32'd0);
    check("mrst_ready", 32'(s_ready), 32'd0);
    check_idle("mrst_pins");
    ARESET = 1'b0;
    enable = 1'b0;
    tick(1);
    check("mrst_ready_back", 32'(s_ready), 32'd1);

    // Enable drop at bitcnt 20, resume on a frame boundary
    push(32'h0F0F_1234);
    push(32'h7E7E_8001);
    enable = 1'b1;
    wait_falls(21);
    enable = 1'b0;
    tick(1);
    check_idle("drop_idle");
    check("drop_level", 32'(fifo_level), 32'd1);
    f0 = frames;
    enable = 1'b1;
    wait_frames(f0 + 1);
    enable = 1'b0;
    tick(1);
    check("final_level", 32'(fifo_level), 32'd0);
    check("final_underrun", 32'(underrun), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_audio_i2s_tx.md
# axi_audio_i2s_tx

Serialising back end of the AXI audio peripheral: accepts 32-bit stereo sample words from the AXI4-Lite register stage via a valid/ready push and buffers them in a small FIFO. Transmits them as standard Philips I2S (16-bit left and right, 32 BCLK per frame), with BCLK and LRCLK derived from ACLK. Sits directly downstream of the slave register file; its outputs go to the codec pins.

## Interface
- FIFO_DEPTH, 16: sample FIFO depth in words; power of two, ≥2.
- BCLK_DIV, 4: ACLK cycles per BCLK half-period; ≥1.
- ACLK  in  1  single clock for the whole block.
- ARESET  in  1  synchronous, active-high reset.
- s_data  in  32  sample word: [31:16] left, [15:0] right, two's complement.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO can accept; reset 0, then !full.
- enable  in  1  level; 1 = run the I2S clocks and drain the FIFO.
- underrun_clr  in  1  one-cycle pulse; clears underrun.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words held; reset 0.
- underrun  out  1  sticky; set when a frame starts with the FIFO empty; reset 0.
- i2s_bclk  out  1  bit clock; reset 0.
- i2s_lrclk  out  1  word select, 0 = left; reset 0.
- i2s_sdata  out  1  serial data, MSB first; reset 0.

## Operation
- **Push:** a word is written when s_valid && s_ready.
  - s_ready = !full, independent of any pop in the same cycle.
  - No bypass: a word pushed in a cycle is not visible to a pop in that same cycle.
- **Idle (enable=0):**
  - Divider counter = 0, bitcnt = 31, shift register = 0.
  - bclk = 0, lrclk = 0, sdata = 0.
  - FIFO contents and underrun are retained; pushes are still accepted.
- **Run (enable=1):**
  - The divider counts 0..BCLK_DIV-1; at terminal count it wraps and bclk toggles.
  - On each bclk falling edge (1→0 toggle), bitcnt advances modulo 32.
- **Frame start (bitcnt 31→0 on a falling edge):**
  - If the FIFO is non-empty, pop one word into the 32-bit shift register.
  - If the FIFO is empty, load 0 and set underrun.
- **Per-bit outputs:**
  - sdata = shreg[31-bitcnt], so bitcnt 0 carries the left MSB and bitcnt 16 carries the right MSB.
  - lrclk = 1 for bitcnt 15..30 and 0 for bitcnt 31 and 0..14. LRCLK therefore changes one BCLK before each channel MSB, as I2S requires.
  - sdata and lrclk are registered and update on the same ACLK edge as the bclk falling toggle. They are stable across the bclk rising edge.
- **Enable deasserted mid-frame:** the block returns to idle on the next ACLK. The current word is discarded and not re-sent.
- **Underrun:**
  - Set and underrun_clr in the same cycle: set wins.
  - The flag has no effect on transmission; zeros are sent for the empty frame.
- **ARESET:** mid-operation it empties the FIFO, clears underrun, and returns to idle with all outputs at their reset values on the next ACLK.

## Timing
- BCLK period = 2·BCLK_DIV ACLK cycles; frame = 64·BCLK_DIV ACLK cycles.
- First bclk rise occurs BCLK_DIV cycles after enable is sampled high. The first fall, which is also the first pop, occurs at 2·BCLK_DIV cycles.
- fifo_level updates the cycle after a push or pop; simultaneous push and pop leaves it unchanged.
- Push to s_ready: when the FIFO becomes full, s_ready is low in the next cycle.
- Latency from push (into an empty FIFO, running) to the left MSB on sdata: until the next frame start, worst case 64·BCLK_DIV + 1 ACLK cycles.

## Structure
- **audio_pkg:**
  - FRAME_BITS = 32, CH_BITS = 16.
  - Sample word layout constants LEFT_MSB = 31, RIGHT_MSB = 15.
  - Shared with the register stage.
- **audio_sample_fifo:** synchronous single-clock FIFO sub-module.
  - Ports: push, pop, din, dout, full, empty, level.
  - Pointers wrap modulo FIFO_DEPTH, with an extra bit for full/empty.
- **Top level:** divider, bitcnt, shift register, lrclk/sdata registers, underrun flag.

## Test plan
- **Basic frame (BCLK_DIV=4):** push 0x0101FFFF, then enable.
  - sdata over 32 falling edges = 0000_0001_0000_0001 followed by sixteen 1s.
  - lrclk low for 16 bits starting one BCLK before bit 0.
  - underrun stays 0 and fifo_level returns to 0.
- **Full:** with enable=0, push 16 words 0xabcd0001 upward.
  - fifo_level = 16 and s_ready = 0.
  - A 17th s_valid is held, and not lost when enable releases space.
  - Words then appear in order.
- **Underrun:** enable with the FIFO empty.
  - underrun = 1 the cycle after the first falling edge; sdata all 0.
  - Pulse underrun_clr in the same cycle as the next frame start with the FIFO still empty: underrun remains 1.
- **Back-to-back frames:** push 0xdead0011 and 0xbeef0011.
  - Consecutive frames carry dead/0011 then beef/0011 with no gap.
  - lrclk period = 32 BCLK.
- **Reset mid-frame:** assert ARESET for 1 cycle at bitcnt = 10 with 3 words queued.
  - Next cycle: fifo_level = 0, s_ready = 0, all I2S outputs 0.
  - s_ready = 1 the cycle after ARESET drops.
- **Enable drop:** deassert enable at bitcnt = 20.
  - Outputs are idle next cycle; fifo_level is unchanged.
  - On re-enable the next queued word starts at a frame start.
